guess_game_ctrl: RTL
====================

# guess_game_ctrl

Sequencing controller for the keypad number-guessing game. It consumes decoded digit events from the keyboard handler, assembles a multi-digit BCD guess, and compares it against a latched secret on Enter. It tracks attempts and runs the INITIAL / GAME / FINAL flow. It sits between the keyboard decode path and the seven-segment/LED display logic.

## Interface
- NUM_DIGITS, 4, number of BCD digits per guess; entry and secret are 4*NUM_DIGITS bits wide.
- MAX_TRIES, 10, number of wrong guesses that ends the game as a loss; range 1..15.

- clk  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous, active-low. RST==0 at a rising edge resets the block.
- start  in  1  one-cycle pulse from the debounced/one-pulsed start button.
- key_valid  in  1  one-cycle pulse: a new key press has been decoded.
- key_num  in  4  decoded digit 0..9 on key_valid; 4'hF means a non-digit key.
- key_enter  in  1  one-cycle pulse: Enter pressed.
- key_clear  in  1  one-cycle pulse: clear/backspace-all pressed.
- secret  in  4*NUM_DIGITS  BCD secret, sampled only on INITIAL->GAME.
- state  out  2  2'b00 INITIAL, 2'b01 GAME, 2'b10 FINAL.
- entry  out  4*NUM_DIGITS  current guess, BCD, right-aligned, zero-filled.
- entry_len  out  3  number of digits entered, 0..NUM_DIGITS.
- tries  out  4  number of completed guesses.
- hint  out  2  00 none, 01 guess too low, 10 guess too high, 11 equal.
- win  out  1  high in FINAL after a correct guess.
- lose  out  1  high in FINAL after MAX_TRIES wrong guesses.

## Operation
- **INITIAL**
  - entry, entry_len, tries, hint, win and lose are held at 0.
  - start: latch secret into an internal register, then go to GAME.
  - All key inputs are ignored.
- **GAME** (per cycle, priority key_enter > key_clear > key_valid; lower-priority events in the same cycle are dropped):
  - **key_enter with entry_len==0:** ignored, no state change.
  - **key_enter with entry_len>0:**
    - Compare entry to the latched secret as unsigned vectors; BCD ordering equals numeric ordering.
    - hint <= 01 if less, 10 if greater, 11 if equal.
    - tries <= tries+1.
    - entry and entry_len are cleared.
    - If equal: go to FINAL and set win=1.
    - Else, if tries+1==MAX_TRIES: go to FINAL and set lose=1.
  - **key_clear:** entry and entry_len cleared; hint and tries unchanged.
  - **key_valid with key_num<=9 and entry_len<NUM_DIGITS:**
    - entry <= {entry[4*NUM_DIGITS-5:0], key_num}.
    - entry_len+1.
  - **key_valid with key_num>9, or with entry_len==NUM_DIGITS:** ignored.
  - start is ignored in GAME.
- **FINAL**
  - entry, tries, hint, win and lose are held.
  - All key inputs are ignored.
  - start: go to INITIAL, clearing all outputs. A second start is needed to begin a new game.
- The secret is never re-sampled during GAME; changes on the secret input mid-game have no effect.
- The tries counter cannot wrap: the game exits at MAX_TRIES.

## Timing
- All outputs are registered. Every response appears at the first rising edge after the input pulse, i.e. visible one cycle later.
- Reset at a rising edge with RST==0: state=INITIAL, entry=0, entry_len=0, tries=0, hint=00, win=0, lose=0. Secret register=0.
- Reset takes priority over every other input in the same cycle. Asserting reset mid-GAME or in FINAL discards the game.
- Input pulses longer than one cycle are treated as repeated events; producing single-cycle pulses is the upstream block's responsibility.
- A guess is resolved in a single cycle: no compare pipeline and no busy signal.
- Back-to-back events on consecutive cycles are all accepted.
- win and lose are never both 1. win or lose is 1 only while state==FINAL.

## Test plan
- **Reset and start:** RST=0 for 2 cycles, then start with secret=16'h1234 → state=01 next cycle; entry=0, tries=0, hint=00.
- **Digit entry and overflow:**
  - key_valid with digits 5,6,7,8,9 → entry=16'h5678, entry_len=4 (the 9 is ignored).
  - key_num=F → no change.
  - key_clear → entry=0, entry_len=0.
- **Too-high and too-low hints:**
  - Enter 5,6,7,8 then key_enter → hint=10, tries=1, entry=0.
  - Enter 1,2 then key_enter → entry compared as 16'h0012 → hint=01, tries=2.
  - key_enter with entry_len=0 → tries stays 2.
- **Win:**
  - Enter 1,2,3,4 then key_enter → hint=11, win=1, state=10.
  - Further key_valid/key_enter → no change.
  - start → state=00 with all outputs 0.
- **Lose:** 10 wrong guesses with MAX_TRIES=10 → after the 10th key_enter, lose=1, win=0, tries=10, state=10.
- **Priority and mid-game reset:**
  - key_enter and key_valid(digit 7) in the same cycle, with entry=16'h0003 → guess 3 is evaluated and the 7 is dropped (entry=0).
  - RST=0 during GAME with tries=4 → all outputs reset at that edge; state=00.

Source files
------------

// File: rtl/guess_game_ctrl.sv
// Keypad number-guessing game sequencer: assembles a BCD guess from digit
// events, compares it to a secret latched at game start, and tracks attempts.
module guess_game_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 10
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    key_valid,
    input  logic [3:0]              key_num,
    input  logic                    key_enter,
    input  logic                    key_clear,
    input  logic [4*NUM_DIGITS-1:0] secret,
    output logic [1:0]              state,
    output logic [4*NUM_DIGITS-1:0] entry,
    output logic [2:0]              entry_len,
    output logic [3:0]              tries,
    output logic [1:0]              hint,
    output logic                    win,
    output logic                    lose
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [2:0] LEN_MAX   = 3'(NUM_DIGITS);
    localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_INITIAL = 2'b00,
        ST_GAME    = 2'b01,
        ST_FINAL   = 2'b10
    } state_t;

    state_t          state_r;
    logic [W-1:0]    secret_r;
    logic [W-1:0]    entry_r;
    logic [2:0]      entry_len_r;
    logic [3:0]      tries_r;
    logic [1:0]      hint_r;
    logic            win_r;
    logic            lose_r;

    logic [1:0]      hint_s;
    logic [3:0]      tries_inc_s;
    logic            digit_ok_s;
    logic [W-1:0]    entry_shift_s;

    // BCD digits order numerically, so a plain unsigned compare suffices
    function automatic logic [1:0] compare_guess(input logic [W-1:0] guess,
                                                 input logic [W-1:0] target);
        logic [1:0] result;
        if (guess < target) begin
            result = 2'b01;
        end else if (guess > target) begin
            result = 2'b10;
        end else begin
            result = 2'b11;
        end
        return result;
    endfunction

    // Guess evaluation and digit-acceptance terms for the current cycle
    always_comb begin
        hint_s        = compare_guess(entry_r, secret_r);
        tries_inc_s   = tries_r + 4'd1;
        entry_shift_s = (entry_r << 4) | W'(key_num);
        if ((key_num <= 4'd9) && (entry_len_r < LEN_MAX)) begin
            digit_ok_s = 1'b1;
        end else begin
            digit_ok_s = 1'b0;
        end
    end

    // Game sequencer with all outputs held in registers
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_r     <= ST_INITIAL;
            secret_r    <= {W{1'b0}};
            entry_r     <= {W{1'b0}};
            entry_len_r <= 3'd0;
            tries_r     <= 4'd0;
            hint_r      <= 2'b00;
            win_r       <= 1'b0;
            lose_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_INITIAL: begin
                    entry_r     <= {W{1'b0}};
                    entry_len_r <= 3'd0;
                    tries_r     <= 4'd0;
                    hint_r      <= 2'b00;
                    win_r       <= 1'b0;
                    lose_r      <= 1'b0;
                    if (start) begin
                        secret_r <= secret;
                        state_r  <= ST_GAME;
                    end
                end
                ST_GAME: begin
                    if (key_enter) begin
                        // An empty entry is not a guess and costs no attempt
                        if (entry_len_r != 3'd0) begin
                            hint_r      <= hint_s;
                            tries_r     <= tries_inc_s;
                            entry_r     <= {W{1'b0}};
                            entry_len_r <= 3'd0;
                            if (hint_s == 2'b11) begin
                                win_r   <= 1'b1;
                                state_r <= ST_FINAL;
                            end else if (tries_inc_s == TRIES_MAX) begin
                                lose_r  <= 1'b1;
                                state_r <= ST_FINAL;
                            end
                        end
                    end else if (key_clear) begin
                        entry_r     <= {W{1'b0}};
                        entry_len_r <= 3'd0;
                    end else if (key_valid && digit_ok_s) begin
                        entry_r     <= entry_shift_s;
                        entry_len_r <= entry_len_r + 3'd1;
                    end
                end
                ST_FINAL: begin
                    if (start) begin
                        state_r     <= ST_INITIAL;
                        entry_r     <= {W{1'b0}};
                        entry_len_r <= 3'd0;
                        tries_r     <= 4'd0;
                        hint_r      <= 2'b00;
                        win_r       <= 1'b0;
                        lose_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_INITIAL;
                    entry_r     <= {W{1'b0}};
                    entry_len_r <= 3'd0;
                    tries_r     <= 4'd0;
                    hint_r      <= 2'b00;
                    win_r       <= 1'b0;
                    lose_r      <= 1'b0;
                end
            endcase
        end
    end

    assign state     = state_r;
    assign entry     = entry_r;
    assign entry_len = entry_len_r;
    assign tries     = tries_r;
    assign hint      = hint_r;
    assign win       = win_r;
    assign lose      = lose_r;

endmodule
